// File: rtl/ext_share_arbiter.sv
// Two-port round-robin arbiter for one shared immediate-extension datapath.
// The extended result is returned through a one-entry response register with backpressure.
module ext_share_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [15:0]      req0_data_i,
    input  logic [1:0]       req0_mode_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [15:0]      req1_data_i,
    input  logic [1:0]       req1_mode_i,
    output logic             req1_ready_o,
    output logic             rsp_valid_o,
    output logic [31:0]      rsp_data_o,
    output logic             rsp_id_o,
    input  logic             rsp_ready_i,
    output logic [CNT_W-1:0] gnt0_cnt_o,
    output logic [CNT_W-1:0] gnt1_cnt_o
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_UPPER  = 2'b10,
        MODE_BRANCH = 2'b11
    } ext_mode_e;

    function automatic logic [31:0] extend(input logic [15:0] d, input logic [1:0] mode);
        logic [31:0] r;
        r = 32'h0;
        case (ext_mode_e'(mode))
            MODE_SEXT:   r = {{16{d[15]}}, d};
            MODE_ZEXT:   r = {16'h0000, d};
            MODE_UPPER:  r = {d, 16'h0000};
            MODE_BRANCH: r = {{14{d[15]}}, d, 2'b00};
            default:     r = 32'h0;
        endcase
        return r;
    endfunction

    logic rr_ptr;
    logic can_accept;
    logic grant0;
    logic grant1;

    // Readies are gated by rst_i so nothing is accepted while reset is held low.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        can_accept = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        can_accept = rst_i && (!rsp_valid_o || rsp_ready_i);
        grant0     = can_accept && req0_valid_i && (!req1_valid_i || !rr_ptr);
        grant1     = can_accept && req1_valid_i && (!req0_valid_i ||  rr_ptr);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= 32'h0;
            rsp_id_o    <= 1'b0;
            rr_ptr      <= 1'b0;
        end else if (grant0) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= extend(req0_data_i, req0_mode_i);
            rsp_id_o    <= 1'b0;
            rr_ptr      <= 1'b1;
        end else if (grant1) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= extend(req1_data_i, req1_mode_i);
            rsp_id_o    <= 1'b1;
            rr_ptr      <= 1'b0;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            gnt0_cnt_o <= '0;
            gnt1_cnt_o <= '0;
        end else begin
            if (grant0 && (gnt0_cnt_o != {CNT_W{1'b1}}))
                gnt0_cnt_o <= gnt0_cnt_o + CNT_W'(1);
            if (grant1 && (gnt1_cnt_o != {CNT_W{1'b1}}))
                gnt1_cnt_o <= gnt1_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ext_share_arbiter.sv
// Directed testbench for ext_share_arbiter: reset, mode sweep, round-robin,
// backpressure, counter saturation (second instance with CNT_W=2) and async reset.
module tb_ext_share_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req1_valid_i;
    logic [15:0] req0_data_i, req1_data_i;
    logic [1:0]  req0_mode_i, req1_mode_i;
    logic        rsp_ready_i;

    logic        req0_ready_o, req1_ready_o, rsp_valid_o, rsp_id_o;
    logic [31:0] rsp_data_o;
    logic [7:0]  gnt0_cnt_o, gnt1_cnt_o;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [31:0] s_rsp_data;
    logic [1:0]  s_gnt0_cnt, s_gnt1_cnt;

    int total = 0;
    int bad   = 0;

    ext_share_arbiter #(.CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_mode_i(req0_mode_i),
        .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_mode_i(req1_mode_i),
        .req1_ready_o(req1_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o),
        .rsp_ready_i(rsp_ready_i),
        .gnt0_cnt_o(gnt0_cnt_o), .gnt1_cnt_o(gnt1_cnt_o)
    );

    ext_share_arbiter #(.CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_mode_i(req0_mode_i),
        .req0_ready_o(s_req0_ready),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_mode_i(req1_mode_i),
        .req1_ready_o(s_req1_ready),
        .rsp_valid_o(s_rsp_valid), .rsp_data_o(s_rsp_data), .rsp_id_o(s_rsp_id),
        .rsp_ready_i(rsp_ready_i),
        .gnt0_cnt_o(s_gnt0_cnt), .gnt1_cnt_o(s_gnt1_cnt)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid_i = 1'b0; req0_data_i = 16'h0; req0_mode_i = 2'b00;
        req1_valid_i = 1'b0; req1_data_i = 16'h0; req1_mode_i = 2'b00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rsp_ready_i = 1'b1;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] sweep_exp [4];

    initial begin
        sweep_exp[0] = 32'hFFFFF234; sweep_exp[1] = 32'h0000F234;
        sweep_exp[2] = 32'hF2340000; sweep_exp[3] = 32'hFFFFC8D0;

        // Reset state, with a request already pending to check ready gating
        idle_inputs();
        rsp_ready_i = 1'b1;
        rst_i = 1'b0;
        req0_valid_i = 1'b1;
        #2;
        check("rst_ready0", {31'b0, req0_ready_o}, 32'd0);
        tick();
        check("rst_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_data", rsp_data_o, 32'h0);
        check("rst_id", {31'b0, rsp_id_o}, 32'd0);
        check("rst_cnt0", {24'b0, gnt0_cnt_o}, 32'd0);
        check("rst_cnt1", {24'b0, gnt1_cnt_o}, 32'd0);
        rst_i = 1'b1;

        // First request, same-cycle ready, one-cycle latency
        req0_data_i = 16'h8001; req0_mode_i = 2'b00;
        #1;
        check("t1_ready0", {31'b0, req0_ready_o}, 32'd1);
        check("t1_ready1", {31'b0, req1_ready_o}, 32'd0);
        tick();
        req0_valid_i = 1'b0;
        check("t1_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("t1_data", rsp_data_o, 32'hFFFF8001);
        check("t1_id", {31'b0, rsp_id_o}, 32'd0);
        check("t1_cnt0", {24'b0, gnt0_cnt_o}, 32'd1);

        // Mode sweep on requester 1, back to back
        req1_valid_i = 1'b1; req1_data_i = 16'hF234;
        for (int m = 0; m < 4; m++) begin
            req1_mode_i = 2'(m);
            #1;
            check($sformatf("sweep_ready1_%0d", m), {31'b0, req1_ready_o}, 32'd1);
            tick();
            check($sformatf("sweep_data_%0d", m), rsp_data_o, sweep_exp[m]);
            check($sformatf("sweep_id_%0d", m), {31'b0, rsp_id_o}, 32'd1);
            check($sformatf("sweep_valid_%0d", m), {31'b0, rsp_valid_o}, 32'd1);
        end
        req1_valid_i = 1'b0;
        check("sweep_cnt1", {24'b0, gnt1_cnt_o}, 32'd4);

        // Round robin with both requesters valid
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = 16'h0001; req0_mode_i = 2'b01;
        req1_valid_i = 1'b1; req1_data_i = 16'h0002; req1_mode_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_ready0_%0d", i), {31'b0, req0_ready_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_ready1_%0d", i), {31'b0, req1_ready_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check($sformatf("rr_id_%0d", i), {31'b0, rsp_id_o}, 32'(i % 2));
            check($sformatf("rr_data_%0d", i), rsp_data_o, (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        check("rr_cnt0", {24'b0, gnt0_cnt_o}, 32'd2);
        check("rr_cnt1", {24'b0, gnt1_cnt_o}, 32'd2);
        idle_inputs();
        tick();
        check("drain_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("drain_data_hold", rsp_data_o, 32'h2);
        check("drain_id_hold", {31'b0, rsp_id_o}, 32'd1);
        // Idle cycle did not rotate priority: last grant was 1, so 0 wins
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        #1;
        check("idle_ptr_ready0", {31'b0, req0_ready_o}, 32'd1);
        idle_inputs();

        // Backpressure
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = 16'h0010; req0_mode_i = 2'b01;
        tick();
        rsp_ready_i = 1'b0;
        req0_data_i = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_ready0_%0d", i), {31'b0, req0_ready_o}, 32'd0);
            check($sformatf("bp_data_%0d", i), rsp_data_o, 32'h10);
            check($sformatf("bp_valid_%0d", i), {31'b0, rsp_valid_o}, 32'd1);
            tick();
        end
        rsp_ready_i = 1'b1;
        #1;
        check("bp_release_ready0", {31'b0, req0_ready_o}, 32'd1);
        tick();
        req0_valid_i = 1'b0;
        check("bp_release_data", rsp_data_o, 32'h20);
        check("bp_release_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("bp_cnt0", {24'b0, gnt0_cnt_o}, 32'd2);

        // Saturation, observed on the CNT_W=2 instance
        do_reset();
        req0_valid_i = 1'b1; req0_data_i = 16'h1234; req0_mode_i = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sat_small_%0d", i), {30'b0, s_gnt0_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
            check($sformatf("sat_wide_%0d", i), {24'b0, gnt0_cnt_o}, 32'(i + 1));
        end
        idle_inputs();

        // Asynchronous reset between edges with a pending response
        do_reset();
        rsp_ready_i = 1'b0;
        req1_valid_i = 1'b1; req1_data_i = 16'h5555; req1_mode_i = 2'b01;
        tick();
        req1_valid_i = 1'b0;
        check("ar_pre_valid", {31'b0, rsp_valid_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        check("ar_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("ar_cnt0", {24'b0, gnt0_cnt_o}, 32'd0);
        check("ar_cnt1", {24'b0, gnt1_cnt_o}, 32'd0);
        rsp_ready_i = 1'b1;
        req1_valid_i = 1'b1; req1_data_i = 16'h0004; req1_mode_i = 2'b11;
        #1;
        check("ar_ready1_in_reset", {31'b0, req1_ready_o}, 32'd0);
        tick();
        rst_i = 1'b1;
        #1;
        check("ar_post_ready1", {31'b0, req1_ready_o}, 32'd1);
        tick();
        req1_valid_i = 1'b0;
        check("ar_post_data", rsp_data_o, 32'h00000010);
        check("ar_post_id", {31'b0, rsp_id_o}, 32'd1);
        check("ar_post_cnt1", {24'b0, gnt1_cnt_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ext_share_arbiter.md
Name: ext_share_arbiter

Overview:
- Shares one immediate-extension datapath between two requesters, e.g. the decode stage (port 0) and a branch/jump target unit (port 1).
- Accepts 16-bit immediates over valid/ready handshakes and arbitrates round-robin.
- Extends each accepted immediate per a per-request mode.
- Returns the 32-bit result, tagged with the requester id, through a one-entry registered response stage with backpressure.

Parameters:
CNT_W, 8, width of each per-requester saturating grant counter

Ports:
clk_i  input  1  system clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
req0_valid_i  input  1  requester 0 has a request
req0_data_i  input  16  requester 0 immediate
req0_mode_i  input  2  requester 0 extension mode
req0_ready_o  output  1  requester 0 request accepted this cycle
req1_valid_i  input  1  requester 1 has a request
req1_data_i  input  16  requester 1 immediate
req1_mode_i  input  2  requester 1 extension mode
req1_ready_o  output  1  requester 1 request accepted this cycle
rsp_valid_o  output  1  response register holds a result
rsp_data_o  output  32  extended result
rsp_id_o  output  1  id of requester that produced the result
rsp_ready_i  input  1  consumer takes the response this cycle
gnt0_cnt_o  output  CNT_W  saturating count of grants to requester 0
gnt1_cnt_o  output  CNT_W  saturating count of grants to requester 1

Behaviour:
- Reset, asynchronous on falling rst_i, held while low:
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0.
  - Round-robin pointer = 0, meaning requester 0 has priority.
  - Both grant counters = 0.
- Extension modes, applied to the 16-bit data d:
  - 00: sign-extend, {16{d[15]}, d}.
  - 01: zero-extend, {16'h0000, d}.
  - 10: upper load, {d, 16'h0000}.
  - 11: branch offset, sign-extend then shift left 2, i.e. {{14{d[15]}}, d, 2'b00}.
- Accept condition:
  - can_accept = !rsp_valid_o || rsp_ready_i.
  - Same-cycle drain plus refill is allowed.
- Arbitration (combinational within the cycle):
  - If can_accept=0, both readies are 0.
  - Otherwise, if only one requester is valid, it is granted.
  - If both are valid, the requester selected by the pointer is granted.
  - At most one reqN_ready_o is high per cycle.
  - reqN_ready_o may depend on reqN_valid_i. Requesters must not make valid depend on ready.
- Grant, at the clock edge where reqN_valid_i && reqN_ready_o:
  - rsp_data_o <= ext(reqN_data_i, reqN_mode_i); rsp_id_o <= N; rsp_valid_o <= 1.
  - Pointer <= the other requester (1-N).
  - gntN_cnt_o increments, saturating at all-ones.
- Latency: the result is visible one cycle after acceptance. Throughput is 1 result/cycle when rsp_ready_i is held high.
- Drain without grant: rsp_valid_o && rsp_ready_i with no grant sets rsp_valid_o <= 0. rsp_data_o and rsp_id_o hold their last values.
- Stall: rsp_valid_o && !rsp_ready_i means rsp_data_o and rsp_id_o are held stable and no request is accepted. Requesters must hold valid, data and mode until accepted.
- Pointer changes only on a grant. Idle cycles do not rotate priority.
- No request is dropped or duplicated. Each accepted request produces exactly one response, in acceptance order.
- Reset asserted mid-transaction:
  - A pending response is discarded.
  - Counters clear.
  - No ready is asserted while rst_i is low.

Test Plan:
- Reset with rsp_ready_i=1, then req0 only, data 16'h8001, mode 00 → req0_ready_o=1 in the same cycle; next cycle rsp_valid_o=1, rsp_data_o=32'hFFFF8001, rsp_id_o=0, gnt0_cnt_o=1.
- Mode sweep on req1, data 16'hF234, modes 00/01/10/11 back-to-back with rsp_ready_i=1 → successive responses FFFFF234, 0000F234, F2340000, FFFFC8D0, all with rsp_id_o=1 and one per cycle.
- Both requesters valid for 4 cycles, req0 data 16'h0001, req1 data 16'h0002, mode 01 → grants alternate 0,1,0,1; rsp_id_o sequence 0,1,0,1; each counter reaches 2.
- Backpressure: rsp_valid_o=1 and rsp_ready_i=0 for 3 cycles with req0 valid → req0_ready_o=0 and rsp_data_o stable throughout. When rsp_ready_i rises, req0 is accepted in that same cycle and its response appears the next cycle with no bubble.
- Saturation: CNT_W=2, 5 consecutive req0 grants → gnt0_cnt_o reads 1,2,3,3,3.
- Async reset: drop rst_i between clock edges while rsp_valid_o=1 → rsp_valid_o and both counters clear immediately, without waiting for a clock edge. After release, req1 with data 16'h0004, mode 11 yields 32'h00000010.
